// File: rtl/sevenseg_pkg.sv
// Shared glyph patterns and digit-slot encoding for the seven-segment scan driver.
// All segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package sevenseg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_U     = 7'b1000001;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // slot      | meaning
    // DIG_UNITS | decimal units of count, carries the change-flash DP
    // DIG_TENS  | '1' when count >= 10, otherwise blank
    // DIG_SPARE | always blank
    // DIG_MODE  | mode glyph selected by ctrl
    typedef enum logic [1:0] {
        DIG_UNITS = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_SPARE = 2'd2,
        DIG_MODE  = 2'd3
    } digit_e;

    function automatic logic [6:0] mode_glyph(input logic [2:0] ctrl);
        mode_glyph = GLYPH_H;
        case (ctrl)
            3'd0:    mode_glyph = GLYPH_U;
            3'd1:    mode_glyph = GLYPH_D;
            3'd2:    mode_glyph = GLYPH_B;
            3'd3:    mode_glyph = GLYPH_L;
            default: mode_glyph = GLYPH_H;
        endcase
    endfunction

endpackage

// File: rtl/sevenseg_scan_driver_seg_decoder.sv
// Decimal digit to active-low seven-segment pattern; anything above 9 renders blank.
module seg_decoder
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = GLYPH_BLANK;
        case (i_digit)
            4'd0:    o_seg = GLYPH_0;
            4'd1:    o_seg = GLYPH_1;
            4'd2:    o_seg = GLYPH_2;
            4'd3:    o_seg = GLYPH_3;
            4'd4:    o_seg = GLYPH_4;
            4'd5:    o_seg = GLYPH_5;
            4'd6:    o_seg = GLYPH_6;
            4'd7:    o_seg = GLYPH_7;
            4'd8:    o_seg = GLYPH_8;
            4'd9:    o_seg = GLYPH_9;
            default: o_seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Four-digit common-anode scan driver: units, tens, spare, mode glyph, with a
// change-flash decimal point. count/ctrl come from a slower clock domain.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100000,
    parameter int BLANK_TICKS = 2000,
    parameter int FLASH_TICKS = 25000000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_count,
    input  logic [2:0] i_ctrl,
    input  logic       i_disp_en,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    localparam int TICK_W  = $clog2(DIGIT_TICKS);
    localparam int FLASH_W = $clog2(FLASH_TICKS + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(DIGIT_TICKS - 1);
    localparam logic [TICK_W-1:0]  TICK_BLANK = TICK_W'(BLANK_TICKS);
    localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_TICKS);

    logic [3:0]         r_count_s1;
    logic [3:0]         r_count_s2;
    logic [2:0]         r_ctrl_s1;
    logic [2:0]         r_ctrl_s2;
    logic [3:0]         r_disp_count;
    logic [2:0]         r_disp_ctrl;
    logic [FLASH_W-1:0] r_flash_cnt;
    logic [TICK_W-1:0]  r_tick_cnt;
    digit_e             r_digit;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    logic               w_count_load;
    logic               w_tens_on;
    logic [3:0]         w_units;
    logic [6:0]         w_units_seg;

    // Two matching samples in a row means all four bits have landed.
    assign w_count_load = (r_count_s2 == r_count_s1);
    assign w_tens_on    = (r_disp_count >= 4'd10);
    assign w_units      = w_tens_on ? (r_disp_count - 4'd10) : r_disp_count;

    seg_decoder u_units_dec (
        .i_digit (w_units),
        .o_seg   (w_units_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count_s1   <= '0;
            r_count_s2   <= '0;
            r_ctrl_s1    <= '0;
            r_ctrl_s2    <= '0;
            r_disp_count <= '0;
            r_disp_ctrl  <= '0;
            r_flash_cnt  <= '0;
        end else begin
            r_count_s1 <= i_count;
            r_count_s2 <= r_count_s1;
            r_ctrl_s1  <= i_ctrl;
            r_ctrl_s2  <= r_ctrl_s1;
            if (r_ctrl_s2 == r_ctrl_s1)
                r_disp_ctrl <= r_ctrl_s2;
            if (w_count_load)
                r_disp_count <= r_count_s2;
            if (w_count_load && (r_count_s2 != r_disp_count))
                r_flash_cnt <= FLASH_LOAD;
            else if (r_flash_cnt != '0)
                r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_digit    <= DIG_UNITS;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
            r_digit    <= digit_e'(r_digit + 2'd1);
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Output stage lags the scan counter by one clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_an  <= 4'b1111;
            r_seg <= GLYPH_BLANK;
            r_dp  <= 1'b1;
        end else if ((r_tick_cnt < TICK_BLANK) || !i_disp_en) begin
            r_an  <= 4'b1111;
            r_seg <= GLYPH_BLANK;
            r_dp  <= 1'b1;
        end else begin
            r_an <= ~(4'b0001 << r_digit);
            r_dp <= 1'b1;
            case (r_digit)
                DIG_UNITS: begin
                    r_seg <= w_units_seg;
                    r_dp  <= (r_flash_cnt == '0);
                end
                DIG_TENS:  r_seg <= w_tens_on ? GLYPH_1 : GLYPH_BLANK;
                DIG_SPARE: r_seg <= GLYPH_BLANK;
                default:   r_seg <= mode_glyph(r_disp_ctrl);
            endcase
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;
    assign o_dp  = r_dp;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with short timing parameters: a cycle model feeds
// a queue of expected outputs; scenario tasks add targeted checks of their own.
module tb_sevenseg_scan_driver;

    localparam int DT = 8;
    localparam int BT = 2;
    localparam int FT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] count = 4'd0;
    logic [2:0] ctrl = 3'd0;
    logic       disp_en = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .DIGIT_TICKS (DT),
        .BLANK_TICKS (BT),
        .FLASH_TICKS (FT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_count   (count),
        .i_ctrl    (ctrl),
        .i_disp_en (disp_en),
        .o_an      (an),
        .o_seg     (seg),
        .o_dp      (dp)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t sb_q[$];
    out_t exp_now;

    logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0, m_disp = 4'd0;
    logic [2:0] m_c1 = 3'd0, m_c2 = 3'd0, m_dctrl = 3'd0;
    int m_flash = 0, m_tick = 0, m_slot = 0;

    function automatic logic [6:0] dec_glyph(input int v);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[v];
    endfunction

    function automatic logic [6:0] mode_glyph_ref(input int c);
        if (c == 0) return 7'b1000001;
        if (c == 1) return 7'b0100001;
        if (c == 2) return 7'b0000011;
        if (c == 3) return 7'b1000111;
        return 7'b0001001;
    endfunction

    always_comb begin
        exp_now = '{an: 4'b1111, seg: 7'h7F, dp: 1'b1};
        if (rst && disp_en && m_tick >= BT) begin
            case (m_slot)
                0: begin
                    exp_now.an  = 4'b1110;
                    exp_now.seg = dec_glyph(int'(m_disp) % 10);
                    exp_now.dp  = (m_flash == 0);
                end
                1: begin
                    exp_now.an  = 4'b1101;
                    exp_now.seg = (m_disp >= 4'd10) ? dec_glyph(1) : 7'h7F;
                end
                2: exp_now.an = 4'b1011;
                default: begin
                    exp_now.an  = 4'b0111;
                    exp_now.seg = mode_glyph_ref(int'(m_dctrl));
                end
            endcase
        end
    end

    always @(posedge clk) begin
        sb_q.push_back(exp_now);
        if (!rst) begin
            m_s1 <= 4'd0; m_s2 <= 4'd0; m_disp <= 4'd0;
            m_c1 <= 3'd0; m_c2 <= 3'd0; m_dctrl <= 3'd0;
            m_flash <= 0; m_tick <= 0; m_slot <= 0;
        end else begin
            m_s1 <= count;
            m_s2 <= m_s1;
            m_c1 <= ctrl;
            m_c2 <= m_c1;
            if (m_c1 == m_c2) m_dctrl <= m_c2;
            if (m_s1 == m_s2 && m_s2 != m_disp) begin
                m_disp  <= m_s2;
                m_flash <= FT;
            end else if (m_flash > 0) begin
                m_flash <= m_flash - 1;
            end
            if (m_tick == DT - 1) begin
                m_tick <= 0;
                m_slot <= (m_slot + 1) % 4;
            end else begin
                m_tick <= m_tick + 1;
            end
        end
    end

    always @(negedge clk) begin
        out_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry queued", $time);
        end else begin
            e = sb_q.pop_front();
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                         $time, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    task automatic test_reset_idle();
        rst = 1'b0; count = 4'd0; ctrl = 3'd0; disp_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%b/%b, expected 1111/1111111/1", an, seg, dp);
        end
        rst = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k % 8 == 1 || k % 8 == 2) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL idle_blank k=%0d: an=%b, expected 1111", k, an);
                end
            end
            if (k == 3 || k == 35) begin
                checks++;
                if ({an, seg} !== {4'b1110, 7'b1000000}) begin
                    errors++;
                    $display("FAIL idle_slot0 k=%0d: an=%b seg=%b, expected 1110 1000000", k, an, seg);
                end
            end
            if (k == 11) begin
                checks++;
                if ({an, seg} !== {4'b1101, 7'h7F}) begin
                    errors++;
                    $display("FAIL idle_slot1 k=%0d: an=%b seg=%b, expected 1101 1111111", k, an, seg);
                end
            end
            if (k == 27) begin
                checks++;
                if ({an, seg} !== {4'b0111, 7'b1000001}) begin
                    errors++;
                    $display("FAIL idle_slot3 k=%0d: an=%b seg=%b, expected 0111 1000001", k, an, seg);
                end
            end
        end
    endtask

    task automatic test_count12();
        count = 4'd12;
        repeat (2) @(negedge clk);
        checks++;
        if (dut.r_disp_count !== 4'd0) begin
            errors++;
            $display("FAIL latency_early: disp_count=%0d after 2 clk, expected 0", dut.r_disp_count);
        end
        @(negedge clk);
        checks++;
        if (dut.r_disp_count !== 4'd12 || dut.r_flash_cnt !== 20) begin
            errors++;
            $display("FAIL latency_load: disp_count=%0d flash=%0d, expected 12 20",
                     dut.r_disp_count, dut.r_flash_cnt);
        end
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (an == 4'b1110) begin
                checks++;
                if (seg !== 7'b0100100 || dp !== ((j <= 20) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("FAIL units12 j=%0d: seg=%b dp=%b, expected 0100100 dp=%b",
                             j, seg, dp, (j <= 20) ? 1'b0 : 1'b1);
                end
            end
            if (an == 4'b1101) begin
                checks++;
                if (seg !== 7'b1111001) begin
                    errors++;
                    $display("FAIL tens12 j=%0d: seg=%b, expected 1111001", j, seg);
                end
            end
            if (j == 20) begin
                checks++;
                if (dut.r_flash_cnt !== 0) begin
                    errors++;
                    $display("FAIL flash_expire: flash=%0d, expected 0", dut.r_flash_cnt);
                end
            end
        end
    endtask

    task automatic test_mode_sweep();
        logic [6:0] tbl [8];
        tbl = '{7'b1000001, 7'b0100001, 7'b0000011, 7'b1000111,
                7'b0001001, 7'b0001001, 7'b0001001, 7'b0001001};
        count = 4'd15;
        for (int c = 0; c < 8; c++) begin
            ctrl = 3'(c);
            for (int j = 1; j <= 40; j++) begin
                @(negedge clk);
                if (j >= 4 && an == 4'b0111) begin
                    checks++;
                    if (seg !== tbl[c]) begin
                        errors++;
                        $display("FAIL mode_glyph ctrl=%0d: seg=%b, expected %b", c, seg, tbl[c]);
                    end
                end
                if (j >= 4 && an == 4'b1110) begin
                    checks++;
                    if (seg !== 7'b0010010) begin
                        errors++;
                        $display("FAIL units15 ctrl=%0d: seg=%b, expected 0010010", c, seg);
                    end
                end
                if (j >= 4 && an == 4'b1101) begin
                    checks++;
                    if (seg !== 7'b1111001) begin
                        errors++;
                        $display("FAIL tens15 ctrl=%0d: seg=%b, expected 1111001", c, seg);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lit;
        lit = 0;
        ctrl = 3'd0;
        count = 4'd5;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (dut.r_flash_cnt != 0) lit++;
            if (k == 10) count = 4'd8;
            if (k == 12) begin
                checks++;
                if (dut.r_flash_cnt !== 11) begin
                    errors++;
                    $display("FAIL flash_before_reload: flash=%0d, expected 11", dut.r_flash_cnt);
                end
            end
            if (k == 13) begin
                checks++;
                if (dut.r_flash_cnt !== 20) begin
                    errors++;
                    $display("FAIL flash_reload: flash=%0d, expected 20", dut.r_flash_cnt);
                end
            end
            if (k == 14) count = 4'd8;
            if (k == 20) begin
                checks++;
                if (dut.r_flash_cnt !== 13) begin
                    errors++;
                    $display("FAIL same_value_no_reload: flash=%0d, expected 13", dut.r_flash_cnt);
                end
            end
        end
        checks++;
        if (lit !== 30) begin
            errors++;
            $display("FAIL flash_total: lit for %0d clk, expected 30", lit);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an == 4'b1101) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_slot1: an never 1101 within 40 clk, expected slot 1");
        end
        count = 4'd7;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an == 4'b1011) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || dut.r_flash_cnt == 0) begin
            errors++;
            $display("FAIL wait_slot2_flash: found=%0d flash=%0d, expected slot 2 with flash active",
                     found, dut.r_flash_cnt);
        end
        rst = 1'b0;
        count = 4'd0;
        @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1} || dut.r_flash_cnt !== 0) begin
            errors++;
            $display("FAIL mid_reset: an=%b seg=%b dp=%b flash=%0d, expected 1111 1111111 1 0",
                     an, seg, dp, dut.r_flash_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2 || k == 3) begin
                checks++;
                if ({an, seg, dp} !== ((k == 2) ? {4'b1111, 7'h7F, 1'b1} : {4'b1110, 7'b1000000, 1'b1})) begin
                    errors++;
                    $display("FAIL post_reset k=%0d: an=%b seg=%b dp=%b", k, an, seg, dp);
                end
            end
        end
    endtask

    task automatic test_disp_en();
        bit found;
        count = 4'd3;
        repeat (10) @(negedge clk);
        disp_en = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            if (j == 20) count = 4'd9;
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL disabled_blank j=%0d: an=%b seg=%b dp=%b, expected blank", j, an, seg, dp);
            end
        end
        disp_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an == 4'b1110) begin found = 1'b1; break; end
        end
        checks++;
        if (!found || seg !== 7'b0010000 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reenable_units: found=%0d seg=%b dp=%b, expected 0010000 dp=1", found, seg, dp);
        end
    endtask

    initial begin
        test_reset_idle();
        test_count12();
        test_mode_sweep();
        test_back_to_back();
        test_reset_mid();
        test_disp_en();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
